// File: rtl/snake_matrix_scan.sv
// snake_matrix_scan: row-multiplexed LED matrix driver.
// Game logic loads a frame and a blink mask through a strobe/ack handshake.
// The data is double-buffered (shadow -> active) and swapped only on frame
// boundaries, so a row is never shown with half-old, half-new data.
// Blinking pixels are gated by a phase bit that toggles every BLINK_DIV frames.
// Optional feature macro: SNAKE_SCAN_BLANK_EN blanks the first cycle of every
// row (cathodes all high, anodes low) to suppress ghosting between rows.
module snake_matrix_scan #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int DWELL     = 4,
  parameter int BLINK_DIV = 16
) (
  input  logic                 in_clka,
  input  logic                 in_restart,
  input  logic [ROWS*COLS-1:0] in_frame_flat,
  input  logic [ROWS*COLS-1:0] in_blink_flat,
  input  logic                 in_load,
  output logic                 out_load_ack,
  output logic [ROWS-1:0]      out_row_cathode,
  output logic [COLS-1:0]      out_column_anode,
  output logic                 out_frame_start,
  output logic                 out_blink_phase
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  // Packed [row][col] view: element [r][c] is bit r*COLS+c of the flat bus.
  typedef logic [ROWS-1:0][COLS-1:0] grid_t;

  // Scan and blink state
  logic [RW-1:0] row_p0;
  logic [DW-1:0] dwell_p0;
  logic [BW-1:0] blink_cnt_p0;
  logic          phase_p0;
  logic          pending_p0;

  // Double buffers
  grid_t shadow_frame_p0;
  grid_t shadow_blink_p0;
  grid_t active_frame_p0;
  grid_t active_blink_p0;

  logic row_last;
  logic dwell_last;
  logic boundary;

  // Active-low one-cold select for the given row.
  function automatic logic [ROWS-1:0] row_select(input logic [RW-1:0] r);
    logic [ROWS-1:0] sel;
    sel    = '1;
    sel[r] = 1'b0;
    return sel;
  endfunction

  // Lit columns of a row: blinking pixels are only shown while phase is 1.
  function automatic logic [COLS-1:0] row_pixels(input grid_t f, input grid_t b,
                                                 input logic [RW-1:0] r, input logic ph);
    return f[r] & (~b[r] | {COLS{ph}});
  endfunction

  assign row_last   = (row_p0 == ROW_LAST);
  assign dwell_last = (dwell_p0 == DWELL_LAST);
  assign boundary   = row_last && dwell_last;

  // Scan counters, blink phase and the shadow/active buffer handshake.
  always_ff @(posedge in_clka) begin
    if (in_restart) begin
      row_p0          <= '0;
      dwell_p0        <= '0;
      blink_cnt_p0    <= '0;
      phase_p0        <= 1'b1;
      pending_p0      <= 1'b0;
      shadow_frame_p0 <= '0;
      shadow_blink_p0 <= '0;
      active_frame_p0 <= '0;
      active_blink_p0 <= '0;
    end else begin
      dwell_p0 <= dwell_last ? '0 : dwell_p0 + 1'b1;
      if (dwell_last) begin
        row_p0 <= row_last ? '0 : row_p0 + 1'b1;
      end
      if (boundary) begin
        if (blink_cnt_p0 == BLINK_LAST) begin
          blink_cnt_p0 <= '0;
          phase_p0     <= ~phase_p0;
        end else begin
          blink_cnt_p0 <= blink_cnt_p0 + 1'b1;
        end
        // A load landing exactly on the boundary bypasses the shadow and
        // takes priority over whatever the shadow still holds.
        if (in_load) begin
          active_frame_p0 <= in_frame_flat;
          active_blink_p0 <= in_blink_flat;
        end else if (pending_p0) begin
          active_frame_p0 <= shadow_frame_p0;
          active_blink_p0 <= shadow_blink_p0;
        end
        pending_p0 <= 1'b0;
      end else if (in_load) begin
        shadow_frame_p0 <= in_frame_flat;
        shadow_blink_p0 <= in_blink_flat;
        pending_p0      <= 1'b1;
      end
    end
  end

  // Registered outputs: present the row selected by the current counter state.
  always_ff @(posedge in_clka) begin
    if (in_restart) begin
      out_load_ack     <= 1'b0;
      out_row_cathode  <= '1;
      out_column_anode <= '0;
      out_frame_start  <= 1'b0;
      out_blink_phase  <= 1'b1;
    end else begin
      out_load_ack    <= in_load;
      out_frame_start <= (row_p0 == '0) && (dwell_p0 == '0);
      out_blink_phase <= phase_p0;
`ifdef SNAKE_SCAN_BLANK_EN
      if (dwell_p0 == '0) begin
        out_row_cathode  <= '1;
        out_column_anode <= '0;
      end else begin
        out_row_cathode  <= row_select(row_p0);
        out_column_anode <= row_pixels(active_frame_p0, active_blink_p0, row_p0, phase_p0);
      end
`else
      out_row_cathode  <= row_select(row_p0);
      out_column_anode <= row_pixels(active_frame_p0, active_blink_p0, row_p0, phase_p0);
`endif
    end
  end

endmodule

// File: doc/snake_matrix_scan.md
# snake_matrix_scan

Parametrised row-scan driver for the snake LED matrix. It takes a flattened pixel frame and a per-pixel blink mask from game logic through a load handshake, double-buffers them, and multiplexes one row at a time onto the cathode and anode lines. It generalises the fixed 8x8 multiplexing in the snake top level to arbitrary matrix sizes. It adds hardware blinking, such as flashing the head LED on death, so game logic does not need to toggle pixels itself.

## Interface
Parameters:
- ROWS, 8, matrix rows (1..16)
- COLS, 8, matrix columns (1..16)
- DWELL, 4, clock cycles each row is held (≥2 with blanking compiled in, ≥1 otherwise)
- BLINK_DIV, 16, frames per blink half-period (≥1)

Ports:
- in_clka  input  1  sole clock; all state updates on rising edge
- in_restart  input  1  synchronous, active-high reset
- in_frame_flat  input  ROWS*COLS  pixel data; bit r*COLS+c = row r, column c, 1 = lit
- in_blink_flat  input  ROWS*COLS  blink mask, same indexing; 1 = pixel blinks
- in_load  input  1  one-cycle strobe: capture in_frame_flat/in_blink_flat
- out_load_ack  output  1  one-cycle pulse, cycle after an accepted in_load
- out_row_cathode  output  ROWS  active-low row select; at most one bit low
- out_column_anode  output  COLS  active-high column data for the selected row
- out_frame_start  output  1  high during the first output cycle of row 0
- out_blink_phase  output  1  1 = blinking pixels currently visible

## Operation
- Single clock, synchronous active-high reset; no other clock is used.
- State:
  - row counter (0..ROWS-1)
  - dwell counter (0..DWELL-1)
  - blink frame counter (0..BLINK_DIV-1)
  - blink phase
  - shadow and active frame/blink buffers
  - pending flag
- Reset:
  - All counters, buffers and pending are cleared to 0; blink phase = 1.
  - out_row_cathode = all 1.
  - out_column_anode = 0.
  - out_load_ack = 0, out_frame_start = 0, out_blink_phase = 1.
- Scan:
  - Dwell increments every cycle. When it wraps from DWELL-1, row increments.
  - When row wraps from ROWS-1, a frame boundary occurs.
- Display value for row r:
  - cathode bit r = 0, all other cathode bits = 1.
  - anode[c] = active_frame[r*COLS+c] & (~active_blink[r*COLS+c] | phase).
- Load handshake:
  - An in_load outside a frame boundary writes the shadow buffers, sets pending and pulses ack.
  - An in_load while pending is already set overwrites the shadow and acks again. Last write wins.
- Frame boundary:
  - If pending is set, active ← shadow and pending clears.
  - If in_load coincides with the boundary cycle, the input data is written directly to the active buffers. Ack still pulses and pending is cleared. This bypass wins over any older shadow data.
- Blink:
  - The frame counter increments at every frame boundary.
  - On wrap from BLINK_DIV-1, phase toggles.
  - The toggle takes effect on the same boundary as a buffer swap.
- in_restart mid-frame or mid-handshake: the reset values are applied on the next edge. Any pending shadow data and any unacked load are discarded.

## Timing
- All outputs are registered. They reflect the counter/buffer state of the previous cycle.
- The first cycle after in_restart deasserts presents row 0, dwell 0, with out_frame_start = 1.
- Frame length = ROWS*DWELL cycles. With defaults, out_frame_start repeats every 32 cycles.
- Load latency:
  - out_load_ack goes high 1 cycle after in_load.
  - The new data appears at the first output cycle of the next frame (or of the frame starting right after a bypass).
- out_blink_phase changes on the out_frame_start cycle only. Its period is 2*BLINK_DIV frames (1024 cycles with defaults).

## Configuration
- SNAKE_SCAN_BLANK_EN defined:
  - Output cycle dwell = 0 of every row drives cathode all 1 and anode 0, to suppress ghosting.
  - The row is lit for DWELL-1 cycles.
  - out_frame_start still marks the row 0 blank cycle.
- Undefined: every row is lit for all DWELL cycles, and no blank cycles exist.

## Test plan
- Reset: hold in_restart 3 cycles → cathode 8'hFF, anode 0, ack 0, phase 1. The first post-reset cycle has frame_start = 1.
- Load/scan: load a diagonal frame (bit r*9 set), blink 0 → ack 1 cycle later. From the next frame, row r shows cathode ~(1<<r) and anode (1<<r), each held 4 cycles (3 lit + 1 blank with SNAKE_SCAN_BLANK_EN).
- Double load: two in_load strobes in one frame with frames A then B → two acks, and frame B is displayed from the next boundary. Frame A is never displayed.
- Boundary bypass: assert in_load on the last cycle of row 7 → ack pulses and the data is visible on the immediately following frame_start.
- Blink: pixel 63 set with blink bit set → it lights in frames 0..15, goes dark in frames 16..31 and lights again at frame 32. Non-blink pixels stay steady.
- Reset mid-frame with a load pending → the shadow is discarded, the output is blank and scanning restarts at row 0.
